// File: rtl/lfsr_rng_stream.sv
// lfsr_rng_stream: pseudo-random sample generator.
//
// A Galois LFSR shifts out one bit per step. OUT_BITS consecutive bits are
// packed into one sample, which is offered on a valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous reset, active-low
//   en           start/continue sample generation
//   seed_load    load seed this cycle (a zero seed is replaced by DEFAULT_SEED)
//   seed         seed value, WIDTH bits
//   out_ready    consumer accepts the current sample
//   out_valid    sample available
//   random_value current sample, OUT_BITS bits
//   seed_err     one-cycle pulse: a zero seed was loaded
//   period_wrap  one-cycle pulse: LFSR stepped back to its start value
//
// Optional feature macro: RNG_PERIOD_CNT_EN enables the start-value register
// and step counter behind period_wrap. Without it period_wrap is tied to 0.
module lfsr_rng_stream #(
    parameter int unsigned      WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
    parameter int unsigned      OUT_BITS     = 4,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                seed_load,
    input  logic [WIDTH-1:0]    seed,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] random_value,
    output logic                seed_err,
    output logic                period_wrap
);

    localparam int unsigned CntW = $clog2(OUT_BITS);

    typedef enum logic [1:0] {StIdle, StGen, StHold} state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    lfsr_q, lfsr_d;
    logic [OUT_BITS-1:0] smp_q, smp_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [OUT_BITS-1:0] rv_q, rv_d;
    logic                valid_q, valid_d;
    logic                seed_err_q, seed_err_d;

    logic                bit_out;
    logic [WIDTH-1:0]    lfsr_step;
    logic [OUT_BITS-1:0] smp_next;

    assign bit_out   = lfsr_q[0];
    assign lfsr_step = {1'b0, lfsr_q[WIDTH-1:1]} ^ (bit_out ? TAPS : '0);
    assign smp_next  = {smp_q[OUT_BITS-2:0], bit_out};

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        smp_d      = smp_q;
        cnt_d      = cnt_q;
        rv_d       = rv_q;
        valid_d    = valid_q;
        seed_err_d = 1'b0;
        if (seed_load) begin
            // Seed load aborts any sample; random_value keeps its old value.
            lfsr_d     = (seed == '0) ? DEFAULT_SEED : seed;
            seed_err_d = (seed == '0);
            state_d    = StIdle;
            valid_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (en) begin
                        state_d = StGen;
                        smp_d   = '0;
                        cnt_d   = '0;
                    end
                end
                StGen: begin
                    lfsr_d = lfsr_step;
                    smp_d  = smp_next;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CntW'(OUT_BITS - 1)) begin
                        rv_d    = smp_next;
                        valid_d = 1'b1;
                        state_d = StHold;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        valid_d = 1'b0;
                        if (en) begin
                            state_d = StGen;
                            smp_d   = '0;
                            cnt_d   = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            lfsr_q     <= DEFAULT_SEED;
            smp_q      <= '0;
            cnt_q      <= '0;
            rv_q       <= '0;
            valid_q    <= 1'b0;
            seed_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            smp_q      <= smp_d;
            cnt_q      <= cnt_d;
            rv_q       <= rv_d;
            valid_q    <= valid_d;
            seed_err_q <= seed_err_d;
        end
    end

    assign out_valid    = valid_q;
    assign random_value = rv_q;
    assign seed_err     = seed_err_q;

`ifdef RNG_PERIOD_CNT_EN
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] pcnt_q, pcnt_d;
    logic             wrap_q, wrap_d;
    logic             step;

    assign step = (state_q == StGen) && !seed_load;

    always_comb begin
        start_d = start_q;
        pcnt_d  = pcnt_q;
        wrap_d  = 1'b0;
        if (seed_load) begin
            // lfsr_d already holds the substituted seed.
            start_d = lfsr_d;
            pcnt_d  = '0;
        end else if (step) begin
            if (lfsr_step == start_q) begin
                wrap_d = 1'b1;
                pcnt_d = '0;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_q <= DEFAULT_SEED;
            pcnt_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            start_q <= start_d;
            pcnt_q  <= pcnt_d;
            wrap_q  <= wrap_d;
        end
    end

    assign period_wrap = wrap_q;
`else
    assign period_wrap = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_rng_stream.sv
module tb_lfsr_rng_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [3:0]  random_value;
    logic        seed_err;
    logic        period_wrap;

    // Small instance for the period check.
    logic        en2 = 1'b0;
    logic        seed_load2 = 1'b0;
    logic [3:0]  seed2 = '0;
    logic        out_valid2;
    logic [2:0]  random_value2;
    logic        seed_err2;
    logic        period_wrap2;

    int checks = 0;
    int errors = 0;
    logic [3:0] sb[$];

    always #5 clk = ~clk;

    lfsr_rng_stream dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .seed_load    (seed_load),
        .seed         (seed),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .random_value (random_value),
        .seed_err     (seed_err),
        .period_wrap  (period_wrap)
    );

    lfsr_rng_stream #(
        .WIDTH        (4),
        .TAPS         (4'h9),
        .OUT_BITS     (3),
        .DEFAULT_SEED (4'h1)
    ) u_per (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en2),
        .seed_load    (seed_load2),
        .seed         (seed2),
        .out_ready    (1'b1),
        .out_valid    (out_valid2),
        .random_value (random_value2),
        .seed_err     (seed_err2),
        .period_wrap  (period_wrap2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted sample is compared with the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_sample", 32'(random_value), 32'hFFFF_FFFF);
            end else begin
                check("sample", 32'(random_value), 32'(sb.pop_front()));
            end
        end
    end

    // Waits for out_valid. The first counted edge is the transition into GEN.
    task automatic run_sample(input logic [15:0] exp_lfsr);
        int n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!out_valid && n < 50);
        check("latency", 32'(n), 32'd5);
        check("lfsr_at_valid", 32'(dut.lfsr_q), 32'(exp_lfsr));
    endtask

    task automatic run_three(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                             input logic [15:0] l0, input logic [15:0] l1,
                             input logic [15:0] l2);
        sb.push_back(s0);
        sb.push_back(s1);
        sb.push_back(s2);
        @(posedge clk);
        #1;
        en = 1'b1;
        out_ready = 1'b1;
        run_sample(l0);
        run_sample(l1);
        run_sample(l2);
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_after_series", 32'(out_valid), 32'd0);
    endtask

    task automatic load_seed(input logic [15:0] s);
        @(posedge clk);
        #1;
        seed_load = 1'b1;
        seed = s;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        seed = 16'h5A5A;
    endtask

    task automatic period_test();
        int cyc = 0;
        int last = -1;
        int pulses = 0;
        @(posedge clk);
        #1;
        seed_load2 = 1'b1;
        seed2 = 4'h1;
        @(posedge clk);
        #1;
        seed_load2 = 1'b0;
        en2 = 1'b1;
        repeat (240) begin
            @(negedge clk);
            cyc++;
            if (period_wrap2) begin
                pulses++;
                // 15 steps take 20 clocks at 3 steps per 4-clock sample.
                if (last >= 0) check("wrap_interval", 32'(cyc - last), 32'd20);
                last = cyc;
            end
        end
`ifdef RNG_PERIOD_CNT_EN
        check("wrap_pulses_seen", 32'(pulses >= 10), 32'd1);
`else
        check("wrap_tied_low", 32'(pulses), 32'd0);
`endif
        en2 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with other inputs driven to arbitrary values.
        en = 1'b1;
        seed_load = 1'b1;
        seed = 16'h0000;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        en = 1'b0;
        seed_load = 1'b0;
        seed = 16'h1234;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_random_value", 32'(random_value), 32'd0);
        check("rst_seed_err", 32'(seed_err), 32'd0);
        check("rst_period_wrap", 32'(period_wrap), 32'd0);
        check("rst_lfsr", 32'(dut.lfsr_q), 32'hACE1);

        // Post-reset sequence from ACE1.
        run_three(4'h8, 4'h7, 4'h2, 16'h1C4E, 16'hC2C4, 16'h562C);

        // Seed 0001, continuous.
        load_seed(16'h0001);
        @(negedge clk);
        check("seed1_seed_err", 32'(seed_err), 32'd0);
        check("seed1_lfsr", 32'(dut.lfsr_q), 32'h0001);
        run_three(4'h8, 4'h0, 4'h1, 16'h1680, 16'h0168, 16'hB416);

        // Backpressure in HOLD.
        load_seed(16'h0001);
        sb.push_back(4'h8);
        en = 1'b1;
        out_ready = 1'b0;
        run_sample(16'h1680);
        repeat (20) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_value", 32'(random_value), 32'h8);
            check("bp_lfsr", 32'(dut.lfsr_q), 32'h1680);
        end
        @(posedge clk);
        #1;
        en = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        repeat (3) @(negedge clk);
        check("bp_idle_lfsr", 32'(dut.lfsr_q), 32'h1680);

        // Zero seed is replaced and flagged for one cycle.
        load_seed(16'h0000);
        @(negedge clk);
        check("zero_seed_err", 32'(seed_err), 32'd1);
        check("zero_seed_lfsr", 32'(dut.lfsr_q), 32'hACE1);
        @(negedge clk);
        check("zero_seed_err_pulse", 32'(seed_err), 32'd0);
        run_three(4'h8, 4'h7, 4'h2, 16'h1C4E, 16'hC2C4, 16'h562C);

        // Seed load on the second GEN cycle aborts the sample.
        @(posedge clk);
        #1;
        en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        seed_load = 1'b1;
        seed = 16'h0001;
        en = 1'b0;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("abort_valid", 32'(out_valid), 32'd0);
        end
        check("abort_lfsr", 32'(dut.lfsr_q), 32'h0001);
        check("abort_value_kept", 32'(random_value), 32'h2);
        sb.push_back(4'h8);
        @(posedge clk);
        #1;
        en = 1'b1;
        run_sample(16'h1680);
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_recover_idle", 32'(out_valid), 32'd0);

        period_test();

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_rng_stream.md
Name: lfsr_rng_stream

Overview:
- Parametrised pseudo-random sample generator; successor to the single-bit counter/shift-register random simulator.
- Galois LFSR of configurable width and taps with seed loading and zero-seed protection.
- Packs OUT_BITS shifted-out bits into one sample and delivers it over a valid/ready handshake.
- Feeds stimulus and test-pattern consumers in the TPAS/VLSI exercises.

Parameters:
- WIDTH, 16, LFSR state width (min 3).
- TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1); bit WIDTH-1 must be 1.
- OUT_BITS, 4, sample width (2..WIDTH).
- DEFAULT_SEED, 16'hACE1, state after reset and substitute for a zero seed; must be nonzero.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- en  in  1  start/continue sample generation.
- seed_load  in  1  load seed this cycle.
- seed  in  WIDTH  seed value.
- out_ready  in  1  consumer accepts sample.
- out_valid  out  1  sample available.
- random_value  out  OUT_BITS  current sample.
- seed_err  out  1  one-cycle pulse: zero seed was loaded.
- period_wrap  out  1  one-cycle pulse: LFSR returned to its start value (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a rising edge): lfsr=DEFAULT_SEED, state=IDLE, out_valid=0, random_value=0, seed_err=0, period_wrap=0, step counter=0.
- LFSR step, Galois: b=lfsr[0]; lfsr <= (lfsr>>1) ^ (b ? TAPS : 0). The sample register shifts left, taking b: smp <= {smp[OUT_BITS-2:0], b}.
- FSM states: IDLE, GEN, HOLD.
- IDLE: en=1 -> GEN, clearing smp and the step counter. No step on this edge.
- GEN: exactly one step per clock.
  - After the OUT_BITS-th step, random_value <= final smp, out_valid <= 1, state <= HOLD.
  - en deasserting mid-GEN does not abort the current sample.
- HOLD: random_value and lfsr stable; out_valid=1.
  - out_ready=1 with en=1 -> GEN, out_valid <= 0.
  - out_ready=1 with en=0 -> IDLE, out_valid <= 0.
  - out_ready=0 -> stay in HOLD, indefinitely.
- Latency: out_valid rises OUT_BITS+1 edges after the edge sampling en=1 in IDLE. Continuous throughput is one sample per OUT_BITS+1 clocks.
- seed_load has priority over everything except reset, in any state:
  - lfsr <= (seed==0) ? DEFAULT_SEED : seed; seed_err <= (seed==0).
  - state <= IDLE, out_valid <= 0; a pending or in-progress sample is discarded.
  - random_value keeps its old value.
- Reset has priority over seed_load. Reset mid-GEN or mid-HOLD discards the sample.
- All-zero state is unreachable: both reset and seed loading guarantee a nonzero state.
- random_value changes only on the HOLD-entry edge.

Optional Feature:
- Macro: RNG_PERIOD_CNT_EN.
- Defined:
  - start_reg captures the start value at reset or seed load (the DEFAULT_SEED substitute when the seed is zero).
  - A WIDTH-bit step counter increments on every step and clears with start_reg updates.
  - When a step produces lfsr==start_reg, period_wrap pulses high for one cycle and the counter clears.
- Undefined: no start_reg or counter logic; period_wrap is tied to 0.

Test Plan:
- Reset with rst_n=0 for 2 clocks and other inputs arbitrary -> out_valid=0, random_value=0, seed_err=0; the first sample after en matches the DEFAULT_SEED=16'hACE1 model.
- seed_load with seed=16'h0001, then en=1 and out_ready=1 held -> successive samples 4'h8, 4'h0, 4'h1. LFSR values after each sample: 16'h1680, 16'h0168, 16'hB416. Each out_valid rises 5 edges after the previous transition into GEN.
- Backpressure: out_ready=0 for 20 clocks in HOLD -> random_value=4'h8 stable, lfsr=16'h1680 unchanged. Then out_ready=1 with en=0 -> IDLE, out_valid=0.
- Zero seed: seed_load with seed=0 -> seed_err=1 for exactly one cycle, lfsr=16'hACE1, and the sample sequence equals the post-reset sequence.
- seed_load=1 (seed=16'h0001) on the 2nd GEN cycle -> state IDLE, out_valid stays 0, lfsr=16'h0001. The next en produces 4'h8.
- With RNG_PERIOD_CNT_EN and WIDTH=4, TAPS=4'h9 (maximal), OUT_BITS=3, seed=4'h1, en=1 and out_ready=1 held -> period_wrap pulses once every 15 steps. Without the macro, period_wrap stays 0.
